ir_frame_assembler: RTL and testbench
=====================================

Name: ir_frame_assembler

Overview:
- Sits directly downstream of the pulse-distance decoder. Consumes its (valid, code) symbol stream: STOP=00, START=01, ZERO=10, ONE=11.
- Packs data bits LSB-first into bytes and buffers one frame. On STOP it checks the Daikin trailing checksum.
- Good frames are streamed out as bytes over a valid/ready handshake toward the UART/formatter. Bad frames are reported and discarded.

Parameters:
- MAXBYTES, 32, buffer capacity in bytes (power of 2).
- AW, 5, log2(MAXBYTES); byte pointer width.

Ports:
- clk  in  1  system clock (12 MHz)
- reset  in  1  asynchronous, active-low reset
- valid  in  1  one-cycle symbol strobe from decoder
- code  in  2  symbol, qualified by valid
- dout  out  8  frame byte
- dvalid  out  1  dout valid
- dready  in  1  consumer accepts dout when dvalid&&dready
- nbytes  out  AW+1  byte count of current/last frame
- frame_ok  out  1  one-cycle pulse after last byte of a good frame is accepted
- frame_err  out  1  one-cycle pulse when a frame is rejected
- dropped  out  1  one-cycle pulse per input symbol discarded while CHECK/DRAIN
- busy  out  1  high in COLLECT, CHECK, DRAIN

Behaviour:
- Reset (async, reset==0):
  - state=IDLE; all outputs 0; bit counter, pointers, sum and overflow cleared.
  - Buffer contents are don't-care.
  - Reset mid-DRAIN aborts without a frame_ok/frame_err pulse.
- IDLE:
  - START → COLLECT. Clears bitcnt, wptr, sum, overflow; nbytes=0.
  - ZERO, ONE and STOP are ignored (not counted as dropped).
- COLLECT:
  - ZERO/ONE shifts a bit into shreg at position bitcnt (first bit = bit0).
  - On the 8th bit: write byte to mem[wptr], wptr++, nbytes++, sum += byte (mod 256), bitcnt=0.
  - A byte completing when nbytes==MAXBYTES sets overflow and is discarded; nbytes saturates at MAXBYTES.
  - START: frame_err pulse, then restart collection exactly as on entry from IDLE.
  - STOP → CHECK.
- CHECK (exactly 1 cycle): ok = all of
  - nbytes>=2
  - bitcnt==0
  - !overflow
  - (sum − mem[nbytes−1]) mod 256 == mem[nbytes−1]; equivalently sum == 2·last (mod 256).
- CHECK outcome:
  - ok → DRAIN with rptr=0.
  - Otherwise frame_err pulses in the cycle after CHECK, then IDLE.
- DRAIN:
  - Present mem[rptr] on dout with dvalid=1.
  - dout is held stable while dvalid && !dready.
  - On handshake: rptr++, dvalid drops for at least 1 cycle (registered read; throughput ≤ 1 byte / 2 cycles).
  - First dvalid is asserted ≤2 cycles after entering DRAIN.
  - After the byte at rptr==nbytes−1 is accepted: frame_ok pulses next cycle, state=IDLE.
- Inputs during CHECK/DRAIN: any valid pulses dropped for 1 cycle and is otherwise ignored, including START.
- Simultaneous events:
  - A valid input in the same cycle as the DRAIN→IDLE transition is treated as arriving in DRAIN, i.e. dropped.
  - frame_ok and frame_err are never high together.
- nbytes holds its value after the frame until the next START.

Test Plan:
- Good frame: START, bits of 0x11,0xDA,0x27,0x00,0x12 (LSB-first; 0x11 → 1,0,0,0,1,0,0,0), STOP, dready=1 → dout sequence 11 DA 27 00 12, five handshakes, then one frame_ok pulse, nbytes=5, frame_err never asserted.
- Bad checksum: same frame with last byte 0x13 → frame_err pulse 1 cycle after CHECK, dvalid never asserted, state IDLE.
- Partial byte: START, 16 data bits, 3 extra bits, STOP → frame_err; nbytes=2.
- Backpressure: good frame with dready held low 10 cycles at byte 2 → dout=0xDA stable for all 10 cycles with dvalid=1, sequence unchanged; also send ONE during DRAIN → one dropped pulse, output unaffected.
- Overflow/restart:
  - 33 bytes with MAXBYTES=32 then STOP → frame_err, nbytes=32.
  - Separately, START after 3 bytes then a valid 2-byte frame 0x05,0x05 → frame_err for the first, then dout 05 05 and frame_ok.
- Reset and idle noise: assert reset mid-DRAIN → dvalid=0 immediately (async), no pulses after release. Data bits before any START → no state change, busy=0.

Source files
------------

// File: rtl/ir_frame_assembler.sv
// ir_frame_assembler: packs decoded IR symbols LSB-first into a one-frame byte
// buffer, verifies the trailing checksum on STOP and streams good frames out.
// Latency: CHECK is one cycle after STOP; the first dvalid comes one cycle into
// DRAIN, and each accepted byte is followed by at least one idle cycle.
// Backpressure: dout/dvalid hold while dready is low. Symbols arriving during
// CHECK or DRAIN are discarded and flagged on 'dropped'.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   valid, code           - symbol strobe and symbol (00 STOP, 01 START, 10 ZERO, 11 ONE)
//   dout, dvalid, dready  - output byte stream
//   nbytes                - byte count of the current or last frame
//   frame_ok, frame_err   - frame result pulses
//   dropped               - symbol discarded while CHECK/DRAIN
//   busy                  - high whenever not IDLE
module ir_frame_assembler #(
  parameter int MAXBYTES = 32,
  parameter int AW       = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid,
  input  logic [1:0]    code,
  output logic [7:0]    dout,
  output logic          dvalid,
  input  logic          dready,
  output logic [AW:0]   nbytes,
  output logic          frame_ok,
  output logic          frame_err,
  output logic          dropped,
  output logic          busy
);

  localparam logic [1:0]  SYM_STOP  = 2'b00;
  localparam logic [1:0]  SYM_START = 2'b01;
  localparam logic [AW:0] MAX_N     = (AW+1)'(MAXBYTES);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DRAIN} state_t;

  state_t         state;
  logic [2:0]     bitcnt;
  logic [7:0]     shreg;
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [7:0]     sum;
  logic [7:0]     last;
  logic           overflow;
  logic [7:0]     mem [MAXBYTES];

  logic [7:0]     byte_asm;
  logic           byte_wr;
  logic           check_ok;

  always_comb begin
    // Shift register with the incoming bit already merged in; on the 8th bit
    // this is the completed byte.
    byte_asm         = shreg;
    byte_asm[bitcnt] = code[0];
    byte_wr  = (state == COLLECT) && valid && code[1] && (bitcnt == 3'd7) && (nbytes != MAX_N);
    // Trailing checksum: sum of all bytes minus the last equals the last,
    // i.e. total sum == 2*last (mod 256). 'last' mirrors mem[nbytes-1].
    check_ok = (nbytes >= (AW+1)'(2)) && (bitcnt == 3'd0) && !overflow &&
               (sum == {last[6:0], 1'b0});
  end

  // Buffer contents need no reset.
  always_ff @(posedge clk) begin
    if (byte_wr) mem[wptr] <= byte_asm;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      sum       <= '0;
      last      <= '0;
      overflow  <= 1'b0;
      dout      <= '0;
      dvalid    <= 1'b0;
      nbytes    <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      dropped   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      dropped   <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (valid) begin
            if (code == SYM_START) begin
              // START inside a frame abandons it and restarts collection.
              if (state == COLLECT) frame_err <= 1'b1;
              state    <= COLLECT;
              busy     <= 1'b1;
              bitcnt   <= '0;
              wptr     <= '0;
              sum      <= '0;
              overflow <= 1'b0;
              nbytes   <= '0;
            end else if (state == COLLECT) begin
              if (code == SYM_STOP) begin
                state <= CHECK;
              end else begin
                shreg  <= byte_asm;
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                  if (nbytes == MAX_N) begin
                    overflow <= 1'b1;
                  end else begin
                    wptr   <= wptr + 1'b1;
                    nbytes <= nbytes + 1'b1;
                    sum    <= sum + byte_asm;
                    last   <= byte_asm;
                  end
                end
              end
            end
          end
        end
        CHECK: begin
          dropped <= valid;
          if (check_ok) begin
            state  <= DRAIN;
            rptr   <= '0;
            dvalid <= 1'b0;
          end else begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        DRAIN: begin
          dropped <= valid;
          if (dvalid) begin
            if (dready) begin
              dvalid <= 1'b0;
              if ({1'b0, rptr} == nbytes - (AW+1)'(1)) begin
                frame_ok <= 1'b1;
                state    <= IDLE;
                busy     <= 1'b0;
              end else begin
                rptr <= rptr + 1'b1;
              end
            end
          end else begin
            // Registered read: the byte appears the cycle after the fetch.
            dout   <= mem[rptr];
            dvalid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_frame_assembler.sv
// Directed bench for ir_frame_assembler: good/bad checksum, partial byte,
// backpressure with a dropped symbol, overflow, restart, reset mid-drain and
// idle noise. Expected values are hand-computed constants.
module tb_ir_frame_assembler;

  localparam logic [1:0] STOP = 2'b00, START = 2'b01, ZERO = 2'b10, ONE = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] code = 2'b00;
  logic [7:0] dout;
  logic       dvalid;
  logic       dready = 1'b1;
  logic [5:0] nbytes;
  logic       frame_ok, frame_err, dropped, busy;

  int errors = 0;
  int checks = 0;
  int n_ok = 0, n_err = 0, n_drop = 0, n_dv = 0;
  logic [7:0] got[$];

  ir_frame_assembler #(.MAXBYTES(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .valid(valid), .code(code),
    .dout(dout), .dvalid(dvalid), .dready(dready), .nbytes(nbytes),
    .frame_ok(frame_ok), .frame_err(frame_err), .dropped(dropped), .busy(busy)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_ok)  n_ok++;
      if (frame_err) n_err++;
      if (dropped)   n_drop++;
      if (dvalid)    n_dv++;
      if (frame_ok && frame_err) begin
        errors++;
        $error("FAIL ok_err_together observed=1 expected=0");
      end
      if (dvalid && dready) got.push_back(dout);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    n_ok = 0; n_err = 0; n_drop = 0; n_dv = 0;
    got.delete();
  endtask

  task automatic send_sym(input logic [1:0] c);
    @(posedge clk); #1;
    valid = 1'b1; code = c;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_sym(b[i] ? ONE : ZERO);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_dvalid(input string tag, input int max);
    int n = 0;
    @(negedge clk);
    while (dvalid !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, dvalid}, 32'd1);
  endtask

  task automatic check_seq(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    logic [39:0] exp_v;
    logic [39:0] obs_v;
    exp_v = {e0, e1, e2, e3, e4};
    obs_v = '1;
    for (int i = 0; i < 5; i++) if (i < got.size()) obs_v[39-8*i -: 8] = got[i];
    chk({tag, "_len"}, got.size(), 32'd5);
    chk({tag, "_hi"}, {24'd0, obs_v[39:32]}, {24'd0, exp_v[39:32]});
    chk({tag, "_lo"}, obs_v[31:0], exp_v[31:0]);
  endtask

  initial begin
    logic stable;
    // Reset state
    #12;
    chk("rst_dvalid", {31'd0, dvalid}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_nbytes", {26'd0, nbytes}, 32'd0);
    chk("rst_pulses", {29'd0, frame_ok, frame_err, dropped}, 32'd0);
    chk("rst_dout",   {24'd0, dout}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Idle noise: data and STOP before START change nothing
    clear_mon();
    send_sym(ONE); send_sym(ZERO); send_sym(STOP); send_sym(ONE);
    @(negedge clk);
    chk("idle_busy",   {31'd0, busy}, 32'd0);
    chk("idle_nbytes", {26'd0, nbytes}, 32'd0);
    chk("idle_events", n_ok + n_err + n_drop + n_dv, 32'd0);

    // Good frame 11 DA 27 00 12 (sum 0x24 = 2*0x12)
    clear_mon();
    dready = 1'b1;
    send_sym(START);
    send_byte(8'h11); send_byte(8'hDA); send_byte(8'h27); send_byte(8'h00); send_byte(8'h12);
    send_sym(STOP);
    wait_idle("good_idle", 100);
    check_seq("good_seq", 8'h11, 8'hDA, 8'h27, 8'h00, 8'h12);
    chk("good_ok",     n_ok, 32'd1);
    chk("good_err",    n_err, 32'd0);
    chk("good_nbytes", {26'd0, nbytes}, 32'd5);

    // Bad checksum: last byte 0x13, frame_err exactly one cycle after CHECK
    clear_mon();
    send_sym(START);
    send_byte(8'h11); send_byte(8'hDA); send_byte(8'h27); send_byte(8'h00); send_byte(8'h13);
    send_sym(STOP);
    @(negedge clk);
    chk("bad_in_check_err",  {31'd0, frame_err}, 32'd0);
    chk("bad_in_check_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("bad_err_pulse", {31'd0, frame_err}, 32'd1);
    chk("bad_idle",      {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("bad_err_cnt", n_err, 32'd1);
    chk("bad_no_dv",   n_dv, 32'd0);
    chk("bad_no_ok",   n_ok, 32'd0);

    // Partial byte: 16 bits + 3 extra
    clear_mon();
    send_sym(START);
    send_byte(8'h11); send_byte(8'h22);
    send_sym(ONE); send_sym(ZERO); send_sym(ONE);
    send_sym(STOP);
    repeat (4) @(negedge clk);
    chk("part_err",    n_err, 32'd1);
    chk("part_nbytes", {26'd0, nbytes}, 32'd2);
    chk("part_no_dv",  n_dv, 32'd0);

    // Backpressure at byte 2, plus a ONE sent during DRAIN
    clear_mon();
    dready = 1'b0;
    send_sym(START);
    send_byte(8'h11); send_byte(8'hDA); send_byte(8'h27); send_byte(8'h00); send_byte(8'h12);
    send_sym(STOP);
    wait_dvalid("bp_first_dv", 10);
    chk("bp_first_byte", {24'd0, dout}, 32'h11);
    @(posedge clk); #1 dready = 1'b1;
    @(posedge clk); #1 dready = 1'b0;
    wait_dvalid("bp_second_dv", 10);
    stable = 1'b1;
    send_sym(ONE);
    repeat (8) begin
      @(negedge clk);
      if (dvalid !== 1'b1 || dout !== 8'hDA) stable = 1'b0;
    end
    chk("bp_stable", {31'd0, stable}, 32'd1);
    chk("bp_dout_da", {24'd0, dout}, 32'hDA);
    @(posedge clk); #1 dready = 1'b1;
    wait_idle("bp_idle", 100);
    check_seq("bp_seq", 8'h11, 8'hDA, 8'h27, 8'h00, 8'h12);
    chk("bp_dropped", n_drop, 32'd1);
    chk("bp_ok",      n_ok, 32'd1);
    chk("bp_err",     n_err, 32'd0);

    // Overflow: 33 bytes into a 32-byte buffer
    clear_mon();
    send_sym(START);
    for (int i = 0; i < 33; i++) send_byte(8'h00);
    send_sym(STOP);
    repeat (4) @(negedge clk);
    chk("ovf_err",    n_err, 32'd1);
    chk("ovf_nbytes", {26'd0, nbytes}, 32'd32);
    chk("ovf_no_dv",  n_dv, 32'd0);

    // Restart: START after 3 bytes, then a valid 05 05 frame
    clear_mon();
    send_sym(START);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_sym(START);
    send_byte(8'h05); send_byte(8'h05);
    send_sym(STOP);
    wait_idle("rs_idle", 100);
    chk("rs_err",    n_err, 32'd1);
    chk("rs_ok",     n_ok, 32'd1);
    chk("rs_len",    got.size(), 32'd2);
    if (got.size() == 2) chk("rs_bytes", {16'd0, got[0], got[1]}, 32'h0505);
    chk("rs_nbytes", {26'd0, nbytes}, 32'd2);

    // Reset mid-DRAIN: dvalid drops asynchronously, no pulses afterwards
    dready = 1'b0;
    send_sym(START);
    send_byte(8'h05); send_byte(8'h05);
    send_sym(STOP);
    wait_dvalid("rd_dv", 10);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("rd_dvalid_async", {31'd0, dvalid}, 32'd0);
    chk("rd_busy_async",   {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    dready = 1'b1;
    clear_mon();
    repeat (10) @(negedge clk);
    chk("rd_no_events", n_ok + n_err + n_drop + n_dv, 32'd0);
    chk("rd_busy",      {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
